// File: rtl/round_shift_sat.sv
// round_shift_sat: round-half-up arithmetic right shift (pre-register) and signed saturation (post-register).
// Rev 1.0
`default_nettype none

module round_shift_sat #(
    parameter int IN_WIDTH  = 19,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 2
) (
    input  logic signed [IN_WIDTH-1:0]  din_i,
    output logic signed [IN_WIDTH:0]    rs_o,
    input  logic signed [IN_WIDTH:0]    sat_i,
    output logic signed [OUT_WIDTH-1:0] sat_o,
    output logic                        sat_flag_o
);
    localparam int SW = IN_WIDTH + 1;

    // Half an LSB of the shifted result; zero when SHIFT is 0.
    localparam logic [SW-1:0] ROUND = (SW'(1) << SHIFT) >> 1;

    localparam logic signed [SW-1:0] MAXP = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINN = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [SW-1:0] w_sum;

    assign w_sum = $signed({din_i[IN_WIDTH-1], din_i}) + $signed(ROUND);
    assign rs_o  = w_sum >>> SHIFT;

    always_comb begin
        sat_o      = sat_i[OUT_WIDTH-1:0];
        sat_flag_o = 1'b0;
        if (sat_i > MAXP) begin
            sat_o      = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            sat_flag_o = 1'b1;
        end else if (sat_i < MINN) begin
            sat_o      = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            sat_flag_o = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/moving_sum_decimator.sv
// moving_sum_decimator: keeps every DECIM-th moving sum, scales by 2^-SHIFT with rounding, saturates.
// Rev 1.0
`default_nettype none

module moving_sum_decimator #(
    parameter int IN_WIDTH  = 19,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 2,
    parameter int DECIM     = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic signed [IN_WIDTH-1:0]  i_tdata,
    input  logic                        i_tvalid,
    output logic                        i_tready,
    output logic signed [OUT_WIDTH-1:0] o_tdata,
    output logic                        o_tvalid,
    input  logic                        o_tready,
    output logic                        o_tuser
);
    localparam int            PW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

    logic [PW-1:0]               phase_q, phase_d;
    logic                        s1_valid_q, s1_valid_d;
    logic signed [IN_WIDTH:0]    s1_data_q, s1_data_d;
    logic                        o_valid_q, o_valid_d;
    logic signed [OUT_WIDTH-1:0] o_data_q, o_data_d;
    logic                        o_user_q, o_user_d;

    logic                        w_flush;
    logic                        w_at_last;
    logic                        w_s2_ready;
    logic                        w_s1_ready;
    logic                        w_in_hs;
    logic                        w_keep;
    logic                        w_move;
    logic signed [IN_WIDTH:0]    w_rs;
    logic signed [OUT_WIDTH-1:0] w_sat;
    logic                        w_sat_flag;

    round_shift_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_rss (
        .din_i      (i_tdata),
        .rs_o       (w_rs),
        .sat_i      (s1_data_q),
        .sat_o      (w_sat),
        .sat_flag_o (w_sat_flag)
    );

    assign w_flush    = !reset | clear;
    assign w_at_last  = (phase_q == LAST);
    assign w_s2_ready = !o_valid_q | o_tready;
    assign w_s1_ready = !s1_valid_q | w_s2_ready;
    // Discarded phases never need pipeline space, so only the kept phase can stall.
    assign i_tready   = !w_at_last | w_s1_ready;
    assign w_in_hs    = i_tvalid & i_tready;
    assign w_keep     = w_in_hs & w_at_last;
    assign w_move     = s1_valid_q & w_s2_ready;

    always_comb begin
        phase_d    = phase_q;
        s1_valid_d = w_keep | (s1_valid_q & !w_move);
        s1_data_d  = w_keep ? w_rs : s1_data_q;
        o_valid_d  = w_move | (o_valid_q & !o_tready);
        o_data_d   = w_move ? w_sat : o_data_q;
        o_user_d   = w_move ? w_sat_flag : o_user_q;
        if (w_in_hs) begin
            phase_d = w_at_last ? '0 : phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            phase_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_user_q   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_user_q   <= o_user_d;
        end
    end

    assign o_tvalid = o_valid_q;
    assign o_tdata  = o_data_q;
    assign o_tuser  = o_user_q;

endmodule

`default_nettype wire

// File: tb/tb_moving_sum_decimator.sv
// tb_moving_sum_decimator: directed table, multi-cycle corner sequences and random scoreboard run.
// Rev 1.0
`default_nettype none

module tb_moving_sum_decimator;
    localparam int IW = 19;
    localparam int OW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, clear;
    logic signed [IW-1:0] i_tdata;
    logic                 i_tvalid, i_tready, o_tvalid, o_tready, o_tuser;
    logic signed [OW-1:0] o_tdata;
    logic signed [IW-1:0] d1_tdata;
    logic                 d1_tvalid, d1_tready, q1_tvalid, q1_tready, q1_tuser;
    logic signed [OW-1:0] q1_tdata;

    int checks = 0;
    int errors = 0;

    moving_sum_decimator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(2), .DECIM(5)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tuser(o_tuser));

    moving_sum_decimator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(2), .DECIM(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear),
        .i_tdata(d1_tdata), .i_tvalid(d1_tvalid), .i_tready(d1_tready),
        .o_tdata(q1_tdata), .o_tvalid(q1_tvalid), .o_tready(q1_tready), .o_tuser(q1_tuser));

    typedef struct {
        logic signed [IW-1:0] din;
        logic signed [OW-1:0] dout;
        logic                 sat;
    } vec_t;

    vec_t        tbl[13];
    logic [16:0] obs[$];
    logic [16:0] exp5[$];
    logic [16:0] exp1[$];
    logic        stall5, stall1;
    logic [16:0] prev5, prev1;

    always @(negedge clk) begin
        if (o_tvalid && o_tready) obs.push_back({o_tuser, o_tdata});
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input int q, input logic s);
        vec_t v;
        v.din  = IW'(d);
        v.dout = OW'(q);
        v.sat  = s;
        return v;
    endfunction

    // Reference: (x + 2) >>> 2 with floor, then clamp to 16-bit signed.
    function automatic logic [16:0] model(input logic signed [IW-1:0] x);
        longint s;
        s = (longint'(x) + 64'sd2) >>> 2;
        if (s > 32767)  return {1'b1, 16'h7FFF};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(s)};
    endfunction

    function automatic logic signed [IW-1:0] rand_data();
        int r;
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) begin
            r = $urandom_range(0, 40);
            return IW'(r - 20);
        end else if (sel == 1) begin
            r = $urandom_range(131060, 131080);
            return ($urandom_range(0, 1) == 1) ? IW'(r) : IW'(-r);
        end
        return IW'($urandom);
    endfunction

    task automatic feed(input int d);
        int k;
        k        = 0;
        i_tvalid = 1'b1;
        i_tdata  = IW'(d);
        @(negedge clk);
        while (!i_tready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!i_tready) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: i_tready=%0b required 1", i_tready);
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_step(inout int ph5, inout int n5, inout int n1);
        if (stall5) begin
            chk("sb5_hold_valid", o_tvalid, 1);
            chk("sb5_hold_data", {o_tuser, o_tdata}, prev5);
        end
        if (o_tvalid && o_tready) begin
            if (exp5.size() == 0) chk("sb5_extra_output", exp5.size(), 1);
            else chk("sb5_data", {o_tuser, o_tdata}, exp5.pop_front());
        end
        stall5 = o_tvalid && !o_tready;
        prev5  = {o_tuser, o_tdata};
        if (i_tvalid && i_tready) begin
            if (ph5 == 4) exp5.push_back(model(i_tdata));
            ph5 = (ph5 == 4) ? 0 : ph5 + 1;
            n5++;
        end
        if (stall1) begin
            chk("sb1_hold_valid", q1_tvalid, 1);
            chk("sb1_hold_data", {q1_tuser, q1_tdata}, prev1);
        end
        if (q1_tvalid && q1_tready) begin
            if (exp1.size() == 0) chk("sb1_extra_output", exp1.size(), 1);
            else chk("sb1_data", {q1_tuser, q1_tdata}, exp1.pop_front());
        end
        stall1 = q1_tvalid && !q1_tready;
        prev1  = {q1_tuser, q1_tdata};
        if (d1_tvalid && d1_tready) begin
            exp1.push_back(model(d1_tdata));
            n1++;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, ph, held, cyc, n5, n1;
        logic exp_rdy, saw_stall;

        tbl[0]  = mk(6, 2, 1'b0);
        tbl[1]  = mk(5, 1, 1'b0);
        tbl[2]  = mk(-6, -1, 1'b0);
        tbl[3]  = mk(-7, -2, 1'b0);
        tbl[4]  = mk(262143, 32767, 1'b1);
        tbl[5]  = mk(-262144, -32768, 1'b1);
        tbl[6]  = mk(131069, 32767, 1'b0);
        tbl[7]  = mk(131070, 32767, 1'b1);
        tbl[8]  = mk(-131074, -32768, 1'b0);
        tbl[9]  = mk(-131075, -32768, 1'b1);
        tbl[10] = mk(2, 1, 1'b0);
        tbl[11] = mk(-2, 0, 1'b0);
        tbl[12] = mk(-3, -1, 1'b0);

        reset = 1'b0; clear = 1'b0;
        i_tvalid = 1'b1; i_tdata = IW'(28); o_tready = 1'b1;
        d1_tvalid = 1'b0; d1_tdata = '0; q1_tready = 1'b1;
        stall5 = 1'b0; stall1 = 1'b0; prev5 = '0; prev1 = '0;

        // Reset held low with traffic offered.
        repeat (3) begin
            @(negedge clk);
            chk("reset_o_tvalid", o_tvalid, 0);
            chk("reset_o_tdata", o_tdata, 0);
            chk("reset_o_tuser", o_tuser, 0);
            chk("reset_i_tready", i_tready, 1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1; i_tvalid = 1'b0;
        obs.delete();
        for (int k = 1; k <= 5; k++) feed(k);
        idle(4);
        chk("reset_seq_count", obs.size(), 1);
        if (obs.size() >= 1) chk("reset_seq_data", $signed(obs[0][15:0]), 1);

        // Table of kept samples: four discarded fillers, then the kept value.
        for (int i = 0; i < 13; i++) begin
            obs.delete();
            for (int k = 0; k < 4; k++) feed(0);
            feed(tbl[i].din);
            idle(4);
            chk("tbl_count", obs.size(), 1);
            if (obs.size() >= 1) begin
                chk("tbl_data", $signed(obs[0][15:0]), tbl[i].dout);
                chk("tbl_tuser", obs[0][16], tbl[i].sat);
            end
        end

        // Latency: output register fills one edge after the stage-1 load.
        for (int k = 0; k < 4; k++) feed(0);
        i_tvalid = 1'b1; i_tdata = IW'(40);
        @(negedge clk);
        chk("lat_i_tready", i_tready, 1);
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        @(negedge clk);
        chk("lat_stage1_only", o_tvalid, 0);
        @(negedge clk);
        chk("lat_o_tvalid", o_tvalid, 1);
        chk("lat_o_tdata", o_tdata, 10);
        idle(2);

        // Backpressure with a continuous ramp of 4*n (output equals n).
        obs.delete();
        cnt = 0; ph = 0; held = 0; cyc = 0; saw_stall = 1'b0;
        while (cnt < 50 && cyc < 400) begin
            i_tvalid = 1'b1;
            i_tdata  = IW'(4 * cnt);
            o_tready = (cyc >= 30);
            @(negedge clk);
            exp_rdy = (ph != 4) || (held < 2) || o_tready;
            chk("bp_i_tready", i_tready, exp_rdy);
            if (!i_tready) saw_stall = 1'b1;
            if (o_tvalid && o_tready) held--;
            if (i_tready) begin
                if (ph == 4) held++;
                ph = (ph == 4) ? 0 : ph + 1;
                cnt++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        i_tvalid = 1'b0; o_tready = 1'b1;
        idle(5);
        chk("bp_inputs_accepted", cnt, 50);
        chk("bp_saw_stall", saw_stall, 1);
        chk("bp_count", obs.size(), 10);
        for (int k = 0; k < 10; k++) begin
            if (k < obs.size()) chk("bp_data", $signed(obs[k][15:0]), 4 + 5 * k);
        end

        // Clear at phase 3 with both stages full.
        o_tready = 1'b0;
        for (int k = 0; k < 13; k++) feed(4 * k);
        chk("clr_pre_o_tvalid", o_tvalid, 1);
        clear = 1'b1; i_tvalid = 1'b1; i_tdata = IW'(3996);
        @(posedge clk);
        #1;
        clear = 1'b0; i_tvalid = 1'b0;
        @(negedge clk);
        chk("clr_o_tvalid", o_tvalid, 0);
        chk("clr_o_tdata", o_tdata, 0);
        chk("clr_o_tuser", o_tuser, 0);
        chk("clr_i_tready", i_tready, 1);
        o_tready = 1'b1;
        obs.delete();
        @(posedge clk);
        #1;
        for (int k = 101; k <= 107; k++) feed(4 * k);
        idle(4);
        chk("clr_post_count", obs.size(), 1);
        if (obs.size() >= 1) chk("clr_post_data", $signed(obs[0][15:0]), 105);

        // Random throttling on both builds against the scoreboard.
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        exp5.delete(); exp1.delete();
        stall5 = 1'b0; stall1 = 1'b0;
        n5 = 0; n1 = 0; ph = 0; cyc = 0;
        while ((n5 < 10000 || n1 < 10000) && cyc < 40000) begin
            i_tvalid  = (n5 < 10000) && ($urandom_range(0, 9) < 7);
            i_tdata   = rand_data();
            d1_tvalid = (n1 < 10000) && ($urandom_range(0, 9) < 7);
            d1_tdata  = rand_data();
            o_tready  = ($urandom_range(0, 9) < 6);
            q1_tready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            sb_step(ph, n5, n1);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rnd_dut5_inputs", n5, 10000);
        chk("rnd_dut1_inputs", n1, 10000);
        i_tvalid = 1'b0; d1_tvalid = 1'b0; o_tready = 1'b1; q1_tready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            sb_step(ph, n5, n1);
            @(posedge clk);
            #1;
        end
        chk("rnd_dut5_drained", exp5.size(), 0);
        chk("rnd_dut1_drained", exp1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
